// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared types and helpers for the N-way instruction-cache
//               controller: controller state encoding, way-index width
//               calculation and line-address alignment.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    // Explicit 3-bit encoding; codes 6 and 7 are illegal and recover to IDLE.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        BUSY        = 3'd1,
        MISS_FETCH  = 3'd2,
        MISS_FILL   = 3'd3,
        PF_HIT_FILL = 3'd4,
        PF_FETCH    = 3'd5
    } icache_state_e;

    // A direct-mapped cache still needs a 1-bit way index on the array port.
    function automatic int way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // Clears the line-offset bits. Works on a 64-bit container so that any
    // address width up to 64 can share one helper; callers cast back down.
    function automatic logic [63:0] line_addr(input logic [63:0] addr,
                                              input int          offset_w);
        return addr & ~((64'd1 << offset_w) - 64'd1);
    endfunction

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_ctrl_nway_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous flush.
//               Flush beats increment; the count sticks at all-ones.
// Ports       : clk   - clock
//               rst_n - asynchronous active-low reset (count -> 0)
//               inc   - increment request
//               flush - clear request (priority over inc)
//               count - current value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         flush,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/icache_ctrl_nway.sv
`default_nettype none
// ============================================================================
// Module      : icache_ctrl_nway
// Description : N-way set-associative instruction-cache controller with
//               miss fill from physical memory, a one-line next-line
//               prefetch buffer and saturating hit/miss counters. Line data
//               lives in external arrays; this block only steers them.
// Ports       : clk, rst_n              - clock, async active-low reset
//               cmem_read/address       - fetch request (held until resp)
//               cmem_resp               - one-cycle fetch completion
//               unleash_cmem_rdata      - enables array read data to fetch
//               hit/hit_way/lru_way     - lookup results from the arrays
//               way_select              - array way index
//               cache_write             - write line, tag and valid bit
//               valid_bit_datain        - valid value written
//               data_src_sel            - fill source: 0 pmem, 1 pf buffer
//               pmem_read/address/resp  - physical memory handshake
//               pf_buf_load             - capture pmem rdata into pf buffer
//               flush_hit/flush_miss    - counter clears
//               hit_count/miss_count    - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module icache_ctrl_nway
    import icache_pkg::*;
#(
    parameter  int WAYS        = 2,
    parameter  int ADDR_W      = 32,
    parameter  int OFFSET_W    = 5,
    parameter  int CNT_W       = 32,
    parameter  int PREFETCH_EN = 1,
    localparam int WAY_W       = way_w(WAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmem_read,
    input  logic [ADDR_W-1:0] cmem_address,
    output logic              cmem_resp,
    output logic              unleash_cmem_rdata,
    input  logic              hit,
    input  logic [WAY_W-1:0]  hit_way,
    input  logic [WAY_W-1:0]  lru_way,
    output logic [WAY_W-1:0]  way_select,
    output logic              cache_write,
    output logic              valid_bit_datain,
    output logic              data_src_sel,
    output logic              pmem_read,
    output logic [ADDR_W-1:0] pmem_address,
    input  logic              pmem_resp,
    output logic              pf_buf_load,
    input  logic              flush_hit,
    input  logic              flush_miss,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam logic              c_PF_EN      = (PREFETCH_EN != 0);
    localparam logic [ADDR_W-1:0] c_LINE_BYTES = ADDR_W'(1) << OFFSET_W;

    icache_state_e     r_state;
    logic              r_pf_valid;
    logic              r_pf_pending;
    logic [ADDR_W-1:0] r_pf_addr;

    logic [ADDR_W-1:0] w_line;
    logic [ADDR_W-1:0] w_next_line;
    logic              w_pf_match;
    logic              w_hit_inc;
    logic              w_miss_inc;

    assign w_line      = ADDR_W'(line_addr(64'(cmem_address), OFFSET_W));
    // Natural modulo-2^ADDR_W wrap: the line after the top line is line 0.
    assign w_next_line = w_line + c_LINE_BYTES;
    // A buffered prefetch line satisfies the demand miss without pmem traffic.
    assign w_pf_match  = c_PF_EN && r_pf_valid && (r_pf_addr == w_line);

    // ------------------------------------------------------------------
    // State machine and prefetch bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pf_valid   <= 1'b0;
            r_pf_pending <= 1'b0;
            r_pf_addr    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Demand traffic always wins over a pending prefetch.
                    if (cmem_read) begin
                        if (!hit) begin
                            r_state <= BUSY;
                        end
                    end else if (r_pf_pending && c_PF_EN) begin
                        r_state <= PF_FETCH;
                    end
                end
                BUSY: begin
                    // Arrays are registered; this cycle re-reads the lookup.
                    if (hit) begin
                        r_state <= IDLE;
                    end else if (w_pf_match) begin
                        r_state <= PF_HIT_FILL;
                    end else begin
                        r_state <= MISS_FETCH;
                    end
                end
                MISS_FETCH: begin
                    if (pmem_resp) begin
                        r_state <= MISS_FILL;
                    end
                end
                MISS_FILL: begin
                    // A fresh miss retargets the prefetcher and drops any
                    // stale buffered line.
                    r_pf_addr    <= w_next_line;
                    r_pf_valid   <= 1'b0;
                    r_pf_pending <= c_PF_EN;
                    r_state      <= IDLE;
                end
                PF_HIT_FILL: begin
                    r_pf_addr    <= w_next_line;
                    r_pf_valid   <= 1'b0;
                    r_pf_pending <= c_PF_EN;
                    r_state      <= IDLE;
                end
                PF_FETCH: begin
                    // Not abortable: a demand request waits for completion.
                    if (pmem_resp) begin
                        r_pf_valid   <= 1'b1;
                        r_pf_pending <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode. Hits answer in the same cycle, so outputs are decoded
    // from state plus inputs; rst_n gating forces them low during reset.
    // ------------------------------------------------------------------
    always_comb begin
        cmem_resp          = 1'b0;
        unleash_cmem_rdata = 1'b0;
        way_select         = '0;
        cache_write        = 1'b0;
        valid_bit_datain   = 1'b0;
        data_src_sel       = 1'b0;
        pmem_read          = 1'b0;
        pmem_address       = '0;
        pf_buf_load        = 1'b0;
        w_hit_inc          = 1'b0;
        w_miss_inc         = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (cmem_read && hit) begin
                        cmem_resp          = 1'b1;
                        unleash_cmem_rdata = 1'b1;
                        way_select         = hit_way;
                        w_hit_inc          = 1'b1;
                    end
                end
                BUSY: begin
                    w_miss_inc = !hit && !w_pf_match;
                end
                MISS_FETCH: begin
                    pmem_read    = 1'b1;
                    pmem_address = w_line;
                end
                MISS_FILL: begin
                    way_select       = lru_way;
                    cache_write      = 1'b1;
                    valid_bit_datain = 1'b1;
                    data_src_sel     = 1'b0;
                end
                PF_HIT_FILL: begin
                    way_select       = lru_way;
                    cache_write      = 1'b1;
                    valid_bit_datain = 1'b1;
                    data_src_sel     = 1'b1;
                    w_hit_inc        = 1'b1;
                end
                PF_FETCH: begin
                    pmem_read    = 1'b1;
                    pmem_address = r_pf_addr;
                    pf_buf_load  = pmem_resp;
                end
                default: begin
                    w_hit_inc = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    sat_counter #(
        .W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_hit_inc),
        .flush (flush_hit),
        .count (hit_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_miss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_miss_inc),
        .flush (flush_miss),
        .count (miss_count)
    );

endmodule : icache_ctrl_nway
`default_nettype wire

// File: tb/tb_icache_ctrl_nway.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_ctrl_nway
// Description : Directed self-checking bench for icache_ctrl_nway (4 ways,
//               4-bit counters, prefetch enabled). Expected values are
//               queued when stimulus is applied and popped at the sample
//               point on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl_nway;

    localparam int WAYS     = 4;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;
    localparam int CNT_W    = 4;
    localparam int WAY_W    = 2;

    logic              clk;
    logic              rst_n;
    logic              cmem_read;
    logic [ADDR_W-1:0] cmem_address;
    logic              cmem_resp;
    logic              unleash_cmem_rdata;
    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic [WAY_W-1:0]  lru_way;
    logic [WAY_W-1:0]  way_select;
    logic              cache_write;
    logic              valid_bit_datain;
    logic              data_src_sel;
    logic              pmem_read;
    logic [ADDR_W-1:0] pmem_address;
    logic              pmem_resp;
    logic              pf_buf_load;
    logic              flush_hit;
    logic              flush_miss;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    int errors = 0;
    int checks = 0;

    string       q_tag[$];
    logic [31:0] q_exp[$];

    icache_ctrl_nway #(
        .WAYS        (WAYS),
        .ADDR_W      (ADDR_W),
        .OFFSET_W    (OFFSET_W),
        .CNT_W       (CNT_W),
        .PREFETCH_EN (1)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cmem_read          (cmem_read),
        .cmem_address       (cmem_address),
        .cmem_resp          (cmem_resp),
        .unleash_cmem_rdata (unleash_cmem_rdata),
        .hit                (hit),
        .hit_way            (hit_way),
        .lru_way            (lru_way),
        .way_select         (way_select),
        .cache_write        (cache_write),
        .valid_bit_datain   (valid_bit_datain),
        .data_src_sel       (data_src_sel),
        .pmem_read          (pmem_read),
        .pmem_address       (pmem_address),
        .pmem_resp          (pmem_resp),
        .pf_buf_load        (pf_buf_load),
        .flush_hit          (flush_hit),
        .flush_miss         (flush_miss),
        .hit_count          (hit_count),
        .miss_count         (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sb_push(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_exp.push_back(v);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp_v;
        checks++;
        if (q_exp.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            tag   = q_tag.pop_front();
            exp_v = q_exp.pop_front();
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset: outputs forced low even with a hit ----
        rst_n        = 1'b0;
        cmem_read    = 1'b1;
        hit          = 1'b1;
        hit_way      = 2'd1;
        cmem_address = '0;
        lru_way      = '0;
        pmem_resp    = 1'b0;
        flush_hit    = 1'b0;
        flush_miss   = 1'b0;
        sb_push("rst_cmem_resp", 0);
        sb_push("rst_unleash", 0);
        sb_push("rst_way_select", 0);
        sb_push("rst_hit_count", 0);
        sb_push("rst_miss_count", 0);
        @(negedge clk);
        sb_check(cmem_resp); sb_check(unleash_cmem_rdata); sb_check(way_select);
        sb_check(hit_count); sb_check(miss_count);

        next_cycle();
        rst_n = 1'b1; cmem_read = 1'b0; hit = 1'b0; hit_way = '0;

        // ---------------- IDLE hit ----------------
        next_cycle();
        cmem_read = 1'b1; hit = 1'b1; hit_way = 2'd1;
        sb_push("hit_resp", 1); sb_push("hit_unleash", 1);
        sb_push("hit_way_select", 1); sb_push("hit_count_before", 0);
        @(negedge clk);
        sb_check(cmem_resp); sb_check(unleash_cmem_rdata);
        sb_check(way_select); sb_check(hit_count);

        next_cycle();
        cmem_read = 1'b0; hit = 1'b0;
        sb_push("hit_count_after", 1);
        @(negedge clk); sb_check(hit_count);

        // ---------------- demand miss ----------------
        next_cycle();
        cmem_address = 32'h1000_0044; lru_way = 2'd2; cmem_read = 1'b1;
        sb_push("miss_idle_no_resp", 0);
        @(negedge clk); sb_check(cmem_resp);

        next_cycle();                                   // BUSY
        sb_push("busy_no_pmem_read", 0);
        @(negedge clk); sb_check(pmem_read);

        next_cycle();                                   // MISS_FETCH
        sb_push("mf_pmem_read", 1);
        sb_push("mf_pmem_address", 32'h1000_0040);
        sb_push("mf_miss_count", 1);
        @(negedge clk);
        sb_check(pmem_read); sb_check(pmem_address); sb_check(miss_count);

        for (int i = 0; i < 4; i++) begin
            next_cycle();
            sb_push("mf_hold_pmem_read", 1);
            @(negedge clk); sb_check(pmem_read);
        end

        next_cycle();
        pmem_resp = 1'b1;
        sb_push("mf_no_pf_buf_load", 0);
        @(negedge clk); sb_check(pf_buf_load);

        next_cycle();                                   // MISS_FILL
        pmem_resp = 1'b0;
        sb_push("fill_cache_write", 1); sb_push("fill_way_select", 2);
        sb_push("fill_data_src", 0); sb_push("fill_valid_in", 1);
        sb_push("fill_no_pmem_read", 0);
        @(negedge clk);
        sb_check(cache_write); sb_check(way_select); sb_check(data_src_sel);
        sb_check(valid_bit_datain); sb_check(pmem_read);

        next_cycle();                                   // IDLE, now hits
        hit = 1'b1; hit_way = 2'd3;
        sb_push("post_fill_resp", 1); sb_push("post_fill_way", 3);
        @(negedge clk); sb_check(cmem_resp); sb_check(way_select);

        // ---------------- next-line prefetch ----------------
        next_cycle();
        cmem_read = 1'b0; hit = 1'b0;
        sb_push("pf_hit_count", 2); sb_push("pf_idle_no_read", 0);
        @(negedge clk); sb_check(hit_count); sb_check(pmem_read);

        next_cycle();                                   // PF_FETCH
        sb_push("pf_pmem_read", 1); sb_push("pf_pmem_address", 32'h1000_0060);
        sb_push("pf_no_load_yet", 0);
        @(negedge clk);
        sb_check(pmem_read); sb_check(pmem_address); sb_check(pf_buf_load);

        next_cycle();
        pmem_resp = 1'b1;
        sb_push("pf_buf_load", 1);
        @(negedge clk); sb_check(pf_buf_load);

        next_cycle();                                   // IDLE, buffer valid
        pmem_resp = 1'b0; cmem_read = 1'b1; cmem_address = 32'h1000_0064;
        hit = 1'b0; lru_way = 2'd1;
        sb_push("pfh_idle_no_read", 0);
        @(negedge clk); sb_check(pmem_read);

        next_cycle();                                   // BUSY
        sb_push("pfh_busy_no_read", 0);
        @(negedge clk); sb_check(pmem_read);

        next_cycle();                                   // PF_HIT_FILL
        sb_push("pfh_cache_write", 1); sb_push("pfh_data_src", 1);
        sb_push("pfh_way_select", 1); sb_push("pfh_no_pmem_read", 0);
        sb_push("pfh_miss_count", 1);
        @(negedge clk);
        sb_check(cache_write); sb_check(data_src_sel); sb_check(way_select);
        sb_check(pmem_read); sb_check(miss_count);

        next_cycle();
        hit = 1'b1; hit_way = 2'd0;
        sb_push("pfh_hit_count", 3); sb_push("pfh_resp", 1);
        @(negedge clk); sb_check(hit_count); sb_check(cmem_resp);

        // ---------------- priority and address wrap ----------------
        next_cycle();                                   // IDLE, pf_pending=1
        cmem_address = 32'hFFFF_FFE4; hit = 1'b0;
        sb_push("wrap_hit_count", 4); sb_push("wrap_no_resp", 0);
        @(negedge clk); sb_check(hit_count); sb_check(cmem_resp);

        next_cycle();
        sb_push("prio_busy_not_pf", 0);
        @(negedge clk); sb_check(pmem_read);

        next_cycle();                                   // MISS_FETCH
        pmem_resp = 1'b1;
        sb_push("wrap_pmem_read", 1); sb_push("wrap_pmem_address", 32'hFFFF_FFE0);
        sb_push("wrap_miss_count", 2);
        @(negedge clk);
        sb_check(pmem_read); sb_check(pmem_address); sb_check(miss_count);

        next_cycle();                                   // MISS_FILL
        pmem_resp = 1'b0; cmem_read = 1'b0;
        sb_push("wrap_fill_write", 1);
        @(negedge clk); sb_check(cache_write);

        next_cycle();                                   // IDLE after abandon
        sb_push("abandon_no_resp", 0); sb_push("abandon_no_write", 0);
        @(negedge clk); sb_check(cmem_resp); sb_check(cache_write);

        next_cycle();                                   // PF_FETCH
        cmem_read = 1'b1; hit = 1'b1;
        sb_push("wrap_pf_read", 1); sb_push("wrap_pf_address", 32'h0000_0000);
        sb_push("pf_wait_no_resp", 0);
        @(negedge clk);
        sb_check(pmem_read); sb_check(pmem_address); sb_check(cmem_resp);

        next_cycle();
        pmem_resp = 1'b1;
        sb_push("pf_wait_load", 1); sb_push("pf_wait_still_no_resp", 0);
        @(negedge clk); sb_check(pf_buf_load); sb_check(cmem_resp);

        next_cycle();                                   // IDLE serves demand
        pmem_resp = 1'b0;
        sb_push("pf_wait_resp", 1);
        @(negedge clk); sb_check(cmem_resp);

        // ---------------- counters: flush and saturation ----------------
        next_cycle();
        flush_hit = 1'b1; cmem_read = 1'b0; hit = 1'b0;
        sb_push("cnt_pre_flush", 5);
        @(negedge clk); sb_check(hit_count);

        next_cycle();
        flush_hit = 1'b0;
        sb_push("cnt_flushed", 0);
        @(negedge clk); sb_check(hit_count);

        next_cycle();
        cmem_read = 1'b1; hit = 1'b1;
        repeat (16) next_cycle();
        cmem_read = 1'b0; hit = 1'b0;
        sb_push("cnt_saturate", 4'hF);
        @(negedge clk); sb_check(hit_count);

        next_cycle();
        cmem_read = 1'b1; hit = 1'b1; flush_hit = 1'b1;
        sb_push("flush_with_hit_resp", 1);
        @(negedge clk); sb_check(cmem_resp);

        next_cycle();
        cmem_read = 1'b0; hit = 1'b0; flush_hit = 1'b0;
        sb_push("flush_beats_inc", 0);
        @(negedge clk); sb_check(hit_count);

        next_cycle();
        flush_miss = 1'b1;
        sb_push("miss_pre_flush", 2);
        @(negedge clk); sb_check(miss_count);

        next_cycle();
        flush_miss = 1'b0;
        sb_push("miss_flushed", 0);
        @(negedge clk); sb_check(miss_count);

        // ---------------- reset mid-transaction ----------------
        next_cycle();
        cmem_read = 1'b1; cmem_address = 32'h2000_0000; hit = 1'b0;
        next_cycle();                                   // BUSY
        next_cycle();                                   // MISS_FETCH
        sb_push("rstmid_pmem_read", 1); sb_push("rstmid_miss_count", 1);
        @(negedge clk); sb_check(pmem_read); sb_check(miss_count);

        #2;
        rst_n = 1'b0;
        #1;
        sb_push("rstmid_read_drop", 0); sb_push("rstmid_miss_clear", 0);
        sb_check(pmem_read); sb_check(miss_count);

        next_cycle();
        rst_n = 1'b1; cmem_read = 1'b0; pmem_resp = 1'b1;
        sb_push("late_resp_no_write", 0); sb_push("late_resp_no_read", 0);
        @(negedge clk); sb_check(cache_write); sb_check(pmem_read);

        next_cycle();
        pmem_resp = 1'b0;
        sb_push("late_resp_still_idle_write", 0); sb_push("late_resp_still_idle_read", 0);
        @(negedge clk); sb_check(cache_write); sb_check(pmem_read);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_icache_ctrl_nway
`default_nettype wire

// File: doc/icache_ctrl_nway.md
Name: icache_ctrl_nway

Overview:
- Parametrised next-generation instruction-cache controller: N-way set-associative lookup, miss fill from physical memory, and a one-line next-line prefetch buffer.
- Saturating hit/miss performance counters with independent flushes.
- Sits between the fetch stage (cmem_* side) and the L2/arbiter (pmem_* side). Drives the external tag/data/valid arrays and prefetch line buffer; holds no line data itself.

Parameters:
- WAYS, 2, associativity; WAY_W = (WAYS>1) ? clog2(WAYS) : 1
- ADDR_W, 32, address width
- OFFSET_W, 5, line-offset bits (32-byte line)
- CNT_W, 32, performance counter width
- PREFETCH_EN, 1, 1 enables next-line prefetch states; 0 removes them

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- cmem_read  in  1  fetch request, held until cmem_resp
- cmem_address  in  ADDR_W  fetch address
- cmem_resp  out  1  one-cycle completion
- unleash_cmem_rdata  out  1  enables read-data mux to fetch
- hit  in  1  tag match in any way (registered arrays)
- hit_way  in  WAY_W  matching way
- lru_way  in  WAY_W  replacement victim
- way_select  out  WAY_W  array way index
- cache_write  out  1  write line, tag, valid
- valid_bit_datain  out  1  valid value written
- data_src_sel  out  1  0 = pmem line, 1 = prefetch buffer
- pmem_read  out  1  memory read, held until pmem_resp
- pmem_address  out  ADDR_W  line-aligned memory address
- pmem_resp  in  1  memory completion
- pf_buf_load  out  1  capture pmem rdata into prefetch buffer
- flush_hit, flush_miss  in  1 each  clear counters
- hit_count, miss_count  out  CNT_W each  counters

Behaviour:
- Reset: one clock, clk. Reset rst_n is asynchronous and active-low.
  - State goes to IDLE.
  - pf_valid=0, pf_pending=0, pf_addr=0, counters=0.
  - All outputs are 0 while rst_n=0.
- line(a) = {a[ADDR_W-1:OFFSET_W], OFFSET_W'b0}.
- pmem_address is line(cmem_address) in MISS_FETCH, pf_addr in PF_FETCH, 0 elsewhere.
- IDLE:
  - cmem_read && hit: same-cycle cmem_resp=1, unleash_cmem_rdata=1, way_select=hit_way, hit_count+1; stay IDLE.
  - cmem_read && !hit: go to BUSY.
  - !cmem_read && pf_pending && PREFETCH_EN: go to PF_FETCH. A demand request always has priority over a pending prefetch.
- BUSY: one cycle, no outputs.
  - hit: go to IDLE. The response comes from IDLE on the next cycle.
  - else PREFETCH_EN && pf_valid && pf_addr==line(cmem_address): go to PF_HIT_FILL.
  - else: go to MISS_FETCH and increment miss_count on this transition.
- MISS_FETCH: pmem_read=1. Go to MISS_FILL on pmem_resp.
- MISS_FILL: one cycle.
  - way_select=lru_way, cache_write=1, valid_bit_datain=1, data_src_sel=0.
  - pf_addr <= line(cmem_address)+2^OFFSET_W, wrapping modulo 2^ADDR_W.
  - pf_valid <= 0; pf_pending <= PREFETCH_EN. Go to IDLE.
- PF_HIT_FILL: one cycle.
  - Same array writes as MISS_FILL, but data_src_sel=1.
  - hit_count+1 (a prefetch hit is not a miss).
  - pf_valid <= 0; pf_addr <= next line; pf_pending <= 1. Go to IDLE.
- PF_FETCH:
  - pmem_read=1; the fetch is not abortable.
  - pf_buf_load = pmem_resp in the same cycle.
  - On pmem_resp: pf_valid <= 1, pf_pending <= 0, go to IDLE.
  - A cmem_read arriving meanwhile waits in place.
- cmem_read deasserted mid-miss: the fill still completes, and no cmem_resp is issued afterwards.
- A new miss overwrites pf_addr and invalidates the buffer.
- Counters saturate at all-ones. Flush has priority over increment in the same cycle; the next value is 0.
- rst_n asserted mid-transaction: pmem_read drops immediately. A late pmem_resp after reset is ignored in IDLE.
- Illegal state encoding: recover to IDLE on the next edge, with all outputs 0.

Decomposition:
- Package icache_pkg:
  - icache_state_e enum (IDLE, BUSY, MISS_FETCH, MISS_FILL, PF_HIT_FILL, PF_FETCH).
  - Function line_addr(addr) and the WAY_W computation.
- Sub-module sat_counter (params W; ports clk, rst_n, inc, flush, count), instantiated twice.

Test Plan:
- Hit: cmem_read=1, hit=1, hit_way=1 in IDLE -> same-cycle cmem_resp=1, way_select=1, hit_count 0->1.
- Miss (WAYS=4, lru_way=2, addr 0x1000_0044): BUSY -> MISS_FETCH with pmem_address=0x1000_0040 and miss_count=1. pmem_resp after 5 cycles -> MISS_FILL (cache_write=1, way_select=2, data_src_sel=0). Hit next -> cmem_resp.
- Prefetch: after the miss above with cmem_read low -> PF_FETCH, pmem_address=0x1000_0060, pf_buf_load on pmem_resp. Then fetch 0x1000_0064 with hit=0 -> PF_HIT_FILL with data_src_sel=1, no pmem_read, hit_count+1.
- Wrap/priority: miss at 0xFFFF_FFE4 -> prefetch address 0x0000_0000. cmem_read asserted in the same IDLE cycle as pf_pending -> BUSY, not PF_FETCH.
- Counters: CNT_W=4, 16 hits -> hit_count=0xF (saturates). flush_hit together with a hit -> 0.
- Reset: rst_n low during MISS_FETCH -> pmem_read=0 asynchronously, state IDLE. pmem_resp one cycle later -> no cache_write.
